// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory bus interface.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmemState_t;

    localparam int          DEF_TIMEOUT_CYCLES = 16;
    localparam logic [31:0] DEF_ERR_RDATA      = 32'hDEADBEEF;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_bus_if_if.sv
// Request/acknowledge memory bus between the pipeline's data port (master) and memory (slave).
interface dmem_bus_if_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_err,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_err,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_timeout_ctr.sv
// Counts BUSY cycles without an ack; expired pulses on the last allowed cycle.
module dmem_timeout_ctr
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int            W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0]  TERM = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)      cnt <= '0;
        else if (clear) cnt <= '0;
        else if (count) cnt <= cnt + 1'b1;
    end

    assign expired = count && (cnt == TERM);
endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus port: stalls the pipeline while one load/store runs on a level req / pulse ack bus (>=3 cycles).
// DMEM_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES BUSY cycles with a sticky bus_err.
module dmem_bus_if
    import dmem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [31:0]   ALUResult,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    output logic          stallM,
    dmem_bus_if_if.master bus
);
    dmemState_t  state, stateNext;
    logic        accessReq, startAccess, timeoutHit;
    logic        weQ;
    logic [31:0] addrQ, wdataQ;

    assign accessReq   = MemReadM | MemWriteM;
    assign startAccess = (state == IDLE) && accessReq;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // DONE always falls back to IDLE so the released instruction cannot re-issue.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accessReq) stateNext = BUSY;
            BUSY:    if (bus.bus_ack || timeoutHit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        stallM      = 1'b0;
        bus.bus_req = 1'b0;
        case (state)
            IDLE: stallM = accessReq;
            BUSY: begin
                stallM      = 1'b1;
                bus.bus_req = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addrQ    <= '0;
            wdataQ   <= '0;
            weQ      <= 1'b0;
            ReadData <= '0;
        end else begin
            if (startAccess) begin
                addrQ  <= wordAlign(ALUResult);
                wdataQ <= WriteData;
                weQ    <= MemWriteM;
            end
            if (state == BUSY && !weQ) begin
                if (bus.bus_ack)     ReadData <= bus.bus_rdata;
                else if (timeoutHit) ReadData <= ERR_RDATA;
            end
        end
    end

    assign bus.bus_addr  = addrQ;
    assign bus.bus_wdata = wdataQ;
    assign bus.bus_we    = weQ;

`ifdef DMEM_TIMEOUT_EN
    logic countEn;
    logic errQ;

    assign countEn = (state == BUSY) && !bus.bus_ack;

    dmem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimeoutCtr (
        .clk    (clk),
        .reset  (reset),
        .clear  (startAccess),
        .count  (countEn),
        .expired(timeoutHit)
    );

    always_ff @(posedge clk) begin
        if (reset)           errQ <= 1'b0;
        else if (timeoutHit) errQ <= 1'b1;
    end

    assign bus.bus_err = errQ;
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
    assign timeoutHit       = 1'b0;
    assign bus.bus_err      = 1'b0;
`endif

endmodule

// File: doc/dmem_bus_if.md
DMEM_BUS_IF -- requirements
Module: dmem_bus_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum BUSY cycles before abort; used only with DMEM_TIMEOUT_EN.
REQ-002 Parameter ERR_RDATA, default 32'hDEADBEEF: read data returned on an aborted access.
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-004 clk  in  1  rising-edge clock shared with the pipeline.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 MemReadM  in  1  memory-stage load request.
REQ-007 MemWriteM  in  1  memory-stage store request.
REQ-008 ALUResult  in  32  memory-stage byte address.
REQ-009 WriteData  in  32  memory-stage store data.
REQ-010 ReadData  out  32  registered load data to the memory/writeback register bank.
REQ-011 stallM  out  1  holds every pipeline stage while an access is outstanding.
REQ-012 bus_req  out  1  bus request, level held until acknowledged.
REQ-013 bus_we  out  1  bus write enable.
REQ-014 bus_addr  out  32  word-aligned bus address.
REQ-015 bus_wdata  out  32  bus write data.
REQ-016 bus_ack  in  1  one-cycle bus completion pulse.
REQ-017 bus_rdata  in  32  bus read data, valid when bus_ack is high.
REQ-018 bus_err  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-020 IDLE transitions:
- MemReadM or MemWriteM high: latch the address, WriteData and we (we = MemWriteM), then go to BUSY.
- Otherwise: remain in IDLE.
REQ-021 When MemReadM and MemWriteM are both high, the access SHALL be treated as a write.
REQ-022 stallM SHALL equal (IDLE and (MemReadM or MemWriteM)) or BUSY; it SHALL be low in DONE.
REQ-023 In BUSY, bus_req SHALL be 1, and bus_addr, bus_wdata and bus_we SHALL stay constant from the latched values.
REQ-024 In every other state, bus_req SHALL be 0.
REQ-025 bus_addr SHALL be {latched_addr[31:2], 2'b00}; address bits [1:0] SHALL be ignored.
REQ-026 In BUSY with bus_ack=1, the block SHALL go to DONE at the next edge.
- For a read, ReadData SHALL load bus_rdata at that same edge.
- For a write, ReadData SHALL hold its previous value.
REQ-027 DONE SHALL last exactly one cycle and SHALL return unconditionally to IDLE, so the released instruction cannot re-issue its access.
REQ-028 A request seen in IDLE during the cycle right after DONE SHALL be treated as a new access.
REQ-029 Minimum access latency SHALL be 3 cycles (IDLE detect, one BUSY cycle, DONE).
REQ-030 bus_ack while not in BUSY SHALL be ignored.

Reset
REQ-031 On reset, at the next edge the block SHALL enter IDLE with the following values:
- ReadData=0
- bus_req=0, bus_we=0
- bus_addr=0, bus_wdata=0
- bus_err=0
- timeout counter=0
REQ-032 A reset during BUSY SHALL abandon the access without waiting for bus_ack.

Configuration
REQ-033 With macro DMEM_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment on each BUSY cycle without bus_ack.
REQ-034 With DMEM_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without bus_ack, the block SHALL take the following actions at the next edge:
- go to DONE
- load ReadData with ERR_RDATA (reads only)
- set bus_err
REQ-035 bus_ack arriving on the terminal count cycle SHALL take priority over the timeout.
REQ-036 Without DMEM_TIMEOUT_EN, BUSY SHALL wait indefinitely, bus_err SHALL be constant 0, and no counter SHALL exist.

Structure
REQ-037 Package dmem_pkg SHALL hold the state typedef (IDLE/BUSY/DONE), the TIMEOUT_CYCLES default and the ERR_RDATA default.
REQ-038 One sub-module, dmem_timeout_ctr, SHALL implement the counter and SHALL be instantiated only under DMEM_TIMEOUT_EN.

Verification
REQ-039 Read: MemReadM=1, ALUResult=32'h0000_0104, bus_ack after 2 BUSY cycles with bus_rdata=32'h1234_5678.
- Required: bus_addr=32'h104.
- Required: stallM high for 3 cycles.
- Required: ReadData=32'h1234_5678 in DONE.
- Required: stallM low in DONE.
REQ-040 Write: MemWriteM=1, ALUResult=32'h0000_0203, WriteData=32'hCAFE_F00D, ack in the first BUSY cycle.
- Required: bus_we=1, bus_addr=32'h200 and bus_wdata=32'hCAFE_F00D, stable through BUSY.
- Required: ReadData unchanged.
REQ-041 Back-to-back: read, then a write presented in the cycle after DONE.
- Required: two distinct bus_req episodes and no duplicate access.
REQ-042 Reset mid-BUSY, followed by a late bus_ack.
- Required: IDLE with bus_req=0 after the reset edge.
- Required: ReadData=0; the late ack is ignored.
REQ-043 DMEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, read with no ack.
- Required: DONE after 4 BUSY cycles, ReadData=32'hDEADBEEF, bus_err=1 held until reset.
- Required without the macro: stallM stays high indefinitely and bus_err=0.
